// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared funct3 codes, FSM states and operand-sign helpers
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Upper funct3 bit separates the divide group from the multiply group.
   function automatic logic is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

   // rs1 is treated as signed for everything except MULHU/DIVU/REMU.
   function automatic logic signed_a(input logic [2:0] f3);
      return !(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
   endfunction

   // rs2 is treated as signed only for MUL/MULH/DIV/REM.
   function automatic logic signed_b(input logic [2:0] f3);
      return (f3 == F3_MUL || f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - restores operand signs on the unsigned product or quotient/remainder
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]        funct3,
   input  logic              sign_a,
   input  logic              sign_b,
   input  logic [2*XLEN-1:0] acc,
   output logic [XLEN-1:0]   value
);

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;

   // Negate the magnitude results and pick the field the instruction returns.
   always_comb begin
      prod  = (sign_a ^ sign_b) ? -acc : acc;
      quo   = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem   = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      value = '0;
      case (funct3)
         F3_MUL:                       value = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: value = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              value = quo;
         F3_REM, F3_REMU:              value = rem;
         default:                      value = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit with register-file writeback
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_addr,
   output logic            busy,
   output logic            done,
   output logic            wb_we,
   output logic [4:0]      wb_addr,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(XLEN);

   state_t            state, state_nxt;
   logic [2:0]        f3_q;
   logic [XLEN-1:0]   a_q, b_q;
   logic              sign_a, sign_b;
   logic [2*XLEN-1:0] acc, mcand;
   logic [XLEN-1:0]   mplr;
   logic [CNT_W-1:0]  cnt;

   logic              sa_c, sb_c;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div_zero, div_ovf, fast;
   logic [XLEN-1:0]   fast_val;
   logic [2*XLEN-1:0] mul_acc_nxt, div_acc_nxt;
   logic [XLEN:0]     rem_sh, diff;
   logic [XLEN-1:0]   fix_val;

   assign busy = (state != S_IDLE);

   // Operand magnitudes and the divide special cases that skip the iteration loop.
   always_comb begin
      sa_c     = signed_a(f3_q) & a_q[XLEN-1];
      sb_c     = signed_b(f3_q) & b_q[XLEN-1];
      mag_a    = sa_c ? -a_q : a_q;
      mag_b    = sb_c ? -b_q : b_q;
      div_zero = is_div(f3_q) && (b_q == '0);
      div_ovf  = (f3_q == F3_DIV || f3_q == F3_REM)
                 && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
      fast     = div_zero || div_ovf;
      fast_val = '0;
      if (div_zero)
         fast_val = f3_q[1] ? a_q : '1;
      else if (div_ovf)
         fast_val = f3_q[1] ? '0 : a_q;
   end

   // One shift-add or restoring-subtract step; the remainder sits in acc's upper half.
   always_comb begin
      mul_acc_nxt = acc + (mplr[0] ? mcand : '0);
      rem_sh      = acc[2*XLEN-1:XLEN-1];
      diff        = rem_sh - {1'b0, mplr};
      div_acc_nxt = diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   end

   muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .funct3 (f3_q),
      .sign_a (sign_a),
      .sign_b (sign_b),
      .acc    (acc),
      .value  (fix_val)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; kill aborts any busy state back to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start && !kill) state_nxt = S_PREP;
         S_PREP:  state_nxt = fast ? S_DONE : S_RUN;
         S_RUN:   if (cnt == CNT_W'(XLEN-1)) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (kill && state != S_IDLE) state_nxt = S_IDLE;
   end

   // Operand capture, iteration datapath and the held result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         f3_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         wb_addr <= '0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         acc     <= '0;
         mcand   <= '0;
         mplr    <= '0;
         cnt     <= '0;
         result  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !kill) begin
                  f3_q    <= funct3;
                  a_q     <= op_a;
                  b_q     <= op_b;
                  wb_addr <= rd_addr;
               end
            end
            S_PREP: begin
               sign_a <= sa_c;
               sign_b <= sb_c;
               acc    <= is_div(f3_q) ? {{XLEN{1'b0}}, mag_a} : '0;
               mcand  <= {{XLEN{1'b0}}, mag_a};
               mplr   <= mag_b;
               cnt    <= '0;
               if (fast && !kill) result <= fast_val;
            end
            S_RUN: begin
               cnt   <= cnt + CNT_W'(1);
               mcand <= mcand << 1;
               if (is_div(f3_q)) begin
                  acc <= div_acc_nxt;
               end else begin
                  acc  <= mul_acc_nxt;
                  mplr <= mplr >> 1;
               end
            end
            S_FIX: begin
               if (!kill) result <= fix_val;
            end
            default: ;
         endcase
      end
   end

   // Registered completion pulse and register-file write enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         done  <= 1'b0;
         wb_we <= 1'b0;
      end else begin
         done  <= (state_nxt == S_DONE);
         wb_we <= (state_nxt == S_DONE) && (wb_addr != 5'd0);
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [4:0]  rd_addr = '0;
   logic        busy, done, wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .kill    (kill),
      .funct3  (funct3),
      .op_a    (op_a),
      .op_b    (op_b),
      .rd_addr (rd_addr),
      .busy    (busy),
      .done    (done),
      .wb_we   (wb_we),
      .wb_addr (wb_addr),
      .result  (result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint    sa = longint'($signed(a));
      longint    sb = longint'($signed(b));
      longint    ua = longint'({32'd0, a});
      longint    ub = longint'({32'd0, b});
      logic [63:0] p;
      int        q;
      p = '0;
      q = 0;
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            q = $signed(a) / $signed(b);
            return q;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            q = $signed(a) % $signed(b);
            return q;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && b == 0) return 2;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 35;
   endfunction

   // Issues one op from IDLE, returns with the bench sitting in the cycle after done.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output int lat,
                         output logic we, output logic [4:0] wa);
      funct3 = f3; op_a = a; op_b = b; rd_addr = rd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1; res = '0; we = 1'b0; wa = '0;
      for (int k = 1; k <= 60; k++) begin
         if (done) begin
            lat = k; res = result; we = wb_we; wa = wb_addr;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
      total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL reset_wb_we got=%0b want=0", wb_we); end
      total++; if (wb_addr !== 5'd0) begin bad++; $display("FAIL reset_wb_addr got=%0d want=0", wb_addr); end
      total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [2:0]  f3s [11] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd5, 3'd6, 3'd4, 3'd6};
      logic [31:0] as  [11] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'hFFFFFFFE, 32'd1234, 32'd5, 32'h80000000, 32'h80000000};
      logic [31:0] bs  [11] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd2, 32'd2, 32'd2,
                                32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] exp [11] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
      int          lats[11] = '{35, 35, 35, 35, 35, 35, 35, 2, 2, 2, 2};
      logic [31:0] res;
      int          lat;
      logic        we;
      logic [4:0]  wa;
      for (int i = 0; i < 11; i++) begin
         run_op(f3s[i], as[i], bs[i], 5'(i + 1), res, lat, we, wa);
         total++; if (res !== exp[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, exp[i]); end
         total++; if (lat !== lats[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, lats[i]); end
         total++; if (we !== 1'b1 || wa !== 5'(i + 1)) begin bad++; $display("FAIL dir%0d_wb got=%0b/%0d want=1/%0d", i, we, wa, i + 1); end
         total++; if (done !== 1'b0 || result !== exp[i]) begin bad++; $display("FAIL dir%0d_hold done=%0b result=%h want 0/%h", i, done, result, exp[i]); end
      end
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [31:0] a, b, res;
      int          lat, sel;
      logic        we;
      logic [4:0]  wa, rd;
      for (int i = 0; i < 40; i++) begin
         f3  = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 20));
         else if (sel == 3) b = -32'($urandom_range(1, 20));
         rd = 5'($urandom_range(0, 31));
         run_op(f3, a, b, rd, res, lat, we, wa);
         total++; if (res !== ref_result(f3, a, b)) begin bad++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h got=%h want=%h", i, f3, a, b, res, ref_result(f3, a, b)); end
         total++; if (lat !== ref_latency(f3, a, b)) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, ref_latency(f3, a, b)); end
         total++; if (we !== (rd != 5'd0) || wa !== rd) begin bad++; $display("FAIL rnd%0d_wb got=%0b/%0d want=%0b/%0d", i, we, wa, rd != 5'd0, rd); end
      end
   endtask

   task automatic test_rd0();
      logic [31:0] res;
      int          lat;
      logic        we;
      logic [4:0]  wa;
      run_op(3'd0, 32'd6, 32'd9, 5'd0, res, lat, we, wa);
      total++; if (lat !== 35) begin bad++; $display("FAIL rd0_done_latency got=%0d want=35", lat); end
      total++; if (we !== 1'b0) begin bad++; $display("FAIL rd0_wb_we got=%0b want=0", we); end
      total++; if (res !== 32'd54) begin bad++; $display("FAIL rd0_result got=%h want=%h", res, 32'd54); end
   endtask

   task automatic test_back_to_back();
      int          dn = 0;
      int          first = -1;
      int          second = -1;
      logic [31:0] res2;
      funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_addr = 5'd3; start = 1'b1;
      for (int k = 1; k <= 36; k++) begin
         @(posedge clk); #1;
         if (done) begin dn++; first = k; end
         if (k == 36) begin
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%0b want=0", busy); end
         end
      end
      total++; if (dn !== 1 || first !== 35) begin bad++; $display("FAIL b2b_first_done count=%0d cyc=%0d want 1/35", dn, first); end
      @(posedge clk); #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_reaccept_busy got=%0b want=1", busy); end
      funct3 = 3'd7; op_a = 32'd100; op_b = 32'd7;
      res2 = '0;
      for (int k = 38; k <= 90; k++) begin
         @(posedge clk); #1;
         if (k == 40) start = 1'b0;
         if (done && second < 0) begin second = k; res2 = result; end
      end
      start = 1'b0;
      total++; if (second !== 71) begin bad++; $display("FAIL b2b_second_done got=%0d want=71", second); end
      total++; if (res2 !== 32'd14) begin bad++; $display("FAIL b2b_second_result got=%h want=%h", res2, 32'd14); end
   endtask

   task automatic test_kill();
      logic [31:0] prev, res;
      int          seen = 0;
      int          lat;
      logic        we;
      logic [4:0]  wa;
      prev = result;
      kill = 1'b1; start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; rd_addr = 5'd9;
      @(posedge clk); #1;
      kill = 1'b0; start = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_idle_start got_busy=%0b want=0", busy); end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL kill_run busy=%0b done=%0b want 0/0", busy, done); end
      total++; if (result !== prev) begin bad++; $display("FAIL kill_result got=%h want=%h", result, prev); end
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL kill_no_done got=%0d want=0", seen); end
      run_op(3'd2, 32'hFFFFFFF0, 32'd16, 5'd4, res, lat, we, wa);
      total++; if (res !== ref_result(3'd2, 32'hFFFFFFF0, 32'd16) || lat !== 35) begin bad++; $display("FAIL kill_after_op got=%h/%0d want=%h/35", res, lat, ref_result(3'd2, 32'hFFFFFFF0, 32'd16)); end
   endtask

   task automatic test_rst_mid();
      funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd_addr = 5'd12; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid busy=%0b done=%0b want 0/0", busy, done); end
      total++; if (result !== 32'd0 || wb_addr !== 5'd0) begin bad++; $display("FAIL rst_mid_regs result=%h wb_addr=%0d want 0/0", result, wb_addr); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_rd0();
      test_back_to_back();
      test_kill();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
